int_gen: RTL and testbench
==========================

Name: int_gen

Overview:
- Bus-side responder and interrupt source paired with the CPU's external interrupt input.
- Holds a small table of trigger PCs and watches the CPU's macroscopic PC. When the PC matches the armed entry, it raises `interrupt`.
- The handler acknowledges by storing to the interrupt address, which the CPU drives out on m_int_addr / m_int_byteen. The acknowledge drops `interrupt`, retires the entry and re-arms on the next one.
- Sits beside the mips top in the system/testbench; its `interrupt` output feeds mips.interrupt.

Parameters:
- DEPTH, 4, number of trigger-PC table entries (power of two).
- IDX_W, 2, log2(DEPTH).
- INT_ADDR, 32'h0000_7F20, word address that acknowledges the interrupt; bits [1:0] ignored.
- HOLDOFF, 3, cycles after an acknowledge before matching resumes (≥1).
- TIMEOUT, 1024, cycles of unacknowledged assertion before timeout_err is set.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- macroscopic_pc  in  32  CPU macroscopic PC.
- m_int_addr  in  32  CPU store address toward the interrupt generator.
- m_int_byteen  in  4  CPU store byte enables toward the interrupt generator.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry index.
- cfg_pc  in  32  trigger PC to load.
- interrupt  out  1  interrupt request to the CPU.
- ack_count  out  16  number of acknowledged interrupts, saturating.
- cur_idx  out  IDX_W  index of the armed entry.
- timeout_err  out  1  sticky flag: assertion exceeded TIMEOUT.

Behaviour:
- Reset (asynchronous, reset=0):
  - interrupt=0, ack_count=0, cur_idx=0, timeout_err=0.
  - All table valid bits=0; state=IDLE; holdoff and timeout counters=0.
- Table write:
  - cfg_we=1 at an edge writes tbl[cfg_idx]=cfg_pc and valid[cfg_idx]=1. Accepted in any state.
- match = valid[cur_idx] && (macroscopic_pc == tbl[cur_idx]).
- ack = (m_int_addr[31:2] == INT_ADDR[31:2]) && (m_int_byteen != 0).
- States:
  - IDLE:
    - match at edge t → state=ASSERT, interrupt=1 visible after edge t (1-cycle latency); timeout counter=0.
    - ack in IDLE is ignored.
  - ASSERT:
    - interrupt held 1.
    - ack at edge t → interrupt=0 after edge t; valid[cur_idx]=0; cur_idx=cur_idx+1 (wraps DEPTH-1→0); ack_count+=1 (holds at 16'hFFFF); state=HOLDOFF; holdoff counter=HOLDOFF-1.
    - Without ack, the timeout counter increments each cycle. When it reaches TIMEOUT-1, timeout_err=1 (sticky until reset); interrupt stays 1 and the state stays ASSERT.
  - HOLDOFF:
    - interrupt=0; the counter decrements each cycle.
    - At 0 → IDLE. match is ignored throughout HOLDOFF.
    - ack is ignored.
- Simultaneous events:
  - cfg_we to cur_idx on the same edge as the ack that retires it: the cfg write wins and valid stays 1. The pointer still advances.
  - cfg_we to cur_idx while in ASSERT: the table updates; the current assertion is unaffected.
  - match and ack on the same edge in IDLE: the match is taken; the ack is ignored.
- Invalid entry: if valid[cur_idx]=0, no match occurs. The block waits in IDLE; the pointer does not skip the entry.
- Reset mid-ASSERT: interrupt drops immediately (asynchronous); the table is cleared.
- Width rules: PC compare is a full 32-bit compare; the ack address compare uses bits [31:2] only.

Test Plan:
- Reset, load tbl[0]=0x3010, drive pc=0x3010 at edge t → interrupt=1 from t+1, cur_idx=0.
- While asserted, drive m_int_addr=0x7F20, byteen=4'b0001 for one cycle → interrupt=0 next cycle, ack_count=1, cur_idx=1. pc=0x3010 during the next 3 cycles causes no assertion.
- Load tbl[3]=0x3000 and tbl[0]=0x3004; retire entries 1-2 so cur_idx=3. Ack entry 3 → cur_idx wraps to 0; pc=0x3004 then fires.
- Assert with TIMEOUT=8 and no ack → timeout_err=1 after 8 cycles of assertion; interrupt still 1. A later ack clears interrupt but timeout_err stays 1.
- During assertion, ack with byteen=0, and separately with addr=0x7F24 → both ignored; interrupt stays 1.
- Assert, then pull reset low mid-cycle → interrupt and ack_count read 0 before the next clock edge. After release, pc=0x3010 does not fire because the table is cleared.

Source files
------------

// File: rtl/int_gen.sv
// rtl/int_gen.sv - PC-triggered interrupt source with store-acknowledge, holdoff and timeout
module int_gen #(
    parameter int          DEPTH    = 4,
    parameter int          IDX_W    = 2,
    parameter logic [31:0] INT_ADDR = 32'h0000_7F20,
    parameter int          HOLDOFF  = 3,
    parameter int          TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_pc,
    output logic             interrupt,
    output logic [15:0]      ack_count,
    output logic [IDX_W-1:0] cur_idx,
    output logic             timeout_err
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam int          HW       = $clog2(HOLDOFF + 1);
    localparam logic [29:0] ACK_WORD = INT_ADDR[31:2];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLDOFF
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       tbl [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [TW-1:0]     tcnt;
    logic [HW-1:0]     hcnt;
    logic              match;
    logic              ack;
    logic              unused_addr_lsbs;

    assign match            = valid[cur_idx] && (macroscopic_pc == tbl[cur_idx]);
    assign ack              = (m_int_addr[31:2] == ACK_WORD) && (m_int_byteen != 4'b0000);
    assign unused_addr_lsbs = ^m_int_addr[1:0];
    assign interrupt        = (state == ST_ASSERT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (match) state_next = ST_ASSERT;
            ST_ASSERT:  if (ack) state_next = ST_HOLDOFF;
            ST_HOLDOFF: if (hcnt == '0) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The cfg write comes last so it overrides the retire-clear of the same entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
            valid       <= '0;
            cur_idx     <= '0;
            ack_count   <= '0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
            hcnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) tcnt <= '0;
                end
                ST_ASSERT: begin
                    if (ack) begin
                        valid[cur_idx] <= 1'b0;
                        cur_idx        <= cur_idx + IDX_W'(1);
                        hcnt           <= HW'(HOLDOFF - 1);
                        if (ack_count != 16'hFFFF) ack_count <= ack_count + 16'd1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (hcnt != '0) hcnt <= hcnt - HW'(1);
                end
                default: ;
            endcase
            if (cfg_we) begin
                tbl[cfg_idx]   <= cfg_pc;
                valid[cfg_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_gen.sv
// tb/tb_int_gen.sv - directed and randomized checks of int_gen against a behavioural model
module tb_int_gen;

    localparam int          TO = 8;
    localparam int          HO = 3;
    localparam logic [31:0] IA = 32'h0000_7F20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_pc = '0;
    logic        interrupt;
    logic [15:0] ack_count;
    logic [1:0]  cur_idx;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 waiting, 1 requesting, 2 quiet period.
    logic [31:0] m_tbl [4];
    bit          m_valid [4];
    int          m_phase, m_idx, m_acks, m_age, m_hold;
    bit          m_err;

    int_gen #(.DEPTH(4), .IDX_W(2), .INT_ADDR(IA), .HOLDOFF(HO), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr),
        .m_int_byteen(byteen), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .interrupt(interrupt), .ack_count(ack_count), .cur_idx(cur_idx),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_tbl[i]   = '0;
            m_valid[i] = 0;
        end
        m_phase = 0; m_idx = 0; m_acks = 0; m_age = 0; m_hold = 0; m_err = 0;
    endtask

    task automatic tick();
        bit hit, acked;
        hit   = m_valid[m_idx] && (pc == m_tbl[m_idx]);
        acked = ((addr >> 2) == (IA >> 2)) && (byteen != 0);
        case (m_phase)
            0: if (hit) begin m_phase = 1; m_age = 0; end
            1: begin
                if (acked) begin
                    m_phase = 2; m_hold = HO; m_valid[m_idx] = 0;
                    m_idx = (m_idx + 1) % 4;
                    if (m_acks < 65535) m_acks++;
                end else begin
                    m_age++;
                    if (m_age >= TO) m_err = 1;
                end
            end
            default: begin m_hold--; if (m_hold == 0) m_phase = 0; end
        endcase
        if (cfg_we) begin m_tbl[cfg_idx] = cfg_pc; m_valid[cfg_idx] = 1; end
        @(posedge clk);
        #1;
        cfg_we = 1'b0; addr = '0; byteen = '0;
    endtask

    task automatic load(input int idx, input logic [31:0] v);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_pc = v;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pc = '0; addr = '0; byteen = '0; cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b exp 0", interrupt); end
        n_tests++; if (ack_count !== 16'd0) begin n_fail++; $display("FAIL reset_acks got %0d exp 0", ack_count); end
        n_tests++; if (cur_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", cur_idx); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", timeout_err); end
    endtask

    task automatic test_basic_ack();
        do_reset();
        load(0, 32'h3010);
        pc = 32'h3010; tick();
        n_tests++; if (interrupt !== 1'b1 || cur_idx !== 2'd0) begin n_fail++; $display("FAIL basic_fire int %b idx %0d exp 1/0", interrupt, cur_idx); end
        addr = 32'h7F20; byteen = 4'b0001; tick();
        n_tests++; if (interrupt !== 1'b0 || ack_count !== 16'd1 || cur_idx !== 2'd1) begin
            n_fail++; $display("FAIL basic_ack int %b acks %0d idx %0d exp 0/1/1", interrupt, ack_count, cur_idx); end
        // Arm entry 1 with the live PC during the quiet period.
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pc = 32'h3010;
        for (int k = 1; k <= HO; k++) begin
            if (k > 1) cfg_we = 1'b0;
            tick();
            n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL holdoff_%0d int %b exp 0", k, interrupt); end
        end
        tick();
        n_tests++; if (interrupt !== 1'b1 || cur_idx !== 2'd1) begin n_fail++; $display("FAIL holdoff_end int %b idx %0d exp 1/1", interrupt, cur_idx); end
    endtask

    task automatic test_bad_ack();
        do_reset();
        load(0, 32'h3010);
        pc = 32'h3010; tick();
        addr = 32'h7F20; byteen = 4'b0000; tick();
        n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL ack_byteen0 int %b exp 1", interrupt); end
        addr = 32'h7F24; byteen = 4'b1111; tick();
        n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL ack_addr24 int %b exp 1", interrupt); end
        addr = 32'h7F23; byteen = 4'b0010; tick();
        n_tests++; if (interrupt !== 1'b0 || ack_count !== 16'd1) begin n_fail++; $display("FAIL ack_lsbs int %b acks %0d exp 0/1", interrupt, ack_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        load(0, 32'h3010);
        pc = 32'h3010; tick();
        pc = 32'h0;
        repeat (TO - 1) tick();
        n_tests++; if (timeout_err !== 1'b0 || interrupt !== 1'b1) begin n_fail++; $display("FAIL timeout_early err %b int %b exp 0/1", timeout_err, interrupt); end
        tick();
        n_tests++; if (timeout_err !== 1'b1 || interrupt !== 1'b1) begin n_fail++; $display("FAIL timeout_set err %b int %b exp 1/1", timeout_err, interrupt); end
        addr = IA; byteen = 4'b1000; tick();
        n_tests++; if (timeout_err !== 1'b1 || interrupt !== 1'b0) begin n_fail++; $display("FAIL timeout_sticky err %b int %b exp 1/0", timeout_err, interrupt); end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [4];
        pcs[0] = 32'h3010; pcs[1] = 32'h3020; pcs[2] = 32'h3030; pcs[3] = 32'h3000;
        do_reset();
        for (int i = 0; i < 4; i++) load(i, pcs[i]);
        for (int i = 0; i < 4; i++) begin
            pc = pcs[i]; tick();
            n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL wrap_fire_%0d int %b exp 1", i, interrupt); end
            addr = IA; byteen = 4'b0100; tick();
            n_tests++; if (cur_idx !== 2'((i + 1) % 4)) begin n_fail++; $display("FAIL wrap_idx_%0d got %0d exp %0d", i, cur_idx, (i + 1) % 4); end
            pc = 32'h0; repeat (HO) tick();
        end
        pc = 32'h3010; tick(); tick();
        n_tests++; if (interrupt !== 1'b0 || cur_idx !== 2'd0) begin n_fail++; $display("FAIL wrap_retired int %b idx %0d exp 0/0", interrupt, cur_idx); end
        pc = 32'h0; load(0, 32'h3004);
        pc = 32'h3004; tick();
        n_tests++; if (interrupt !== 1'b1 || ack_count !== 16'd4) begin n_fail++; $display("FAIL wrap_refire int %b acks %0d exp 1/4", interrupt, ack_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load(0, 32'h3010); load(1, 32'h3010);
        pc = 32'h3010; tick();
        addr = IA; byteen = 4'b0001; tick();
        repeat (HO + 1) tick();
        n_tests++; if (interrupt !== 1'b1 || ack_count !== 16'd1) begin n_fail++; $display("FAIL areset_pre int %b acks %0d exp 1/1", interrupt, ack_count); end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_tests++; if (interrupt !== 1'b0 || ack_count !== 16'd0) begin n_fail++; $display("FAIL areset_now int %b acks %0d exp 0/0", interrupt, ack_count); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        pc = 32'h3010; tick(); tick();
        n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL areset_cleared int %b exp 0", interrupt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cfg_we  = ($urandom_range(0, 99) < 15);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_pc  = 32'h3000 + 32'($urandom_range(0, 7) * 4);
            pc      = ($urandom_range(0, 1) == 1) ? m_tbl[m_idx] : 32'h3000 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 99) < 30) begin
                addr   = ($urandom_range(0, 3) == 0) ? 32'h7F24 : (IA | 32'($urandom_range(0, 3)));
                byteen = 4'($urandom_range(0, 15));
            end
            tick();
            n_tests++; if (interrupt !== (m_phase == 1)) begin n_fail++; $display("FAIL rnd_int c%0d got %b exp %b", c, interrupt, m_phase == 1); end
            n_tests++; if (cur_idx !== 2'(m_idx)) begin n_fail++; $display("FAIL rnd_idx c%0d got %0d exp %0d", c, cur_idx, m_idx); end
            n_tests++; if (ack_count !== 16'(m_acks)) begin n_fail++; $display("FAIL rnd_acks c%0d got %0d exp %0d", c, ack_count, m_acks); end
            n_tests++; if (timeout_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d got %b exp %b", c, timeout_err, m_err); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_ack();
        test_bad_ack();
        test_timeout();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
